// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and sequencer state encoding for the decimal arithmetic datapath.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_RADIX   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : bcd_pkg

// File: rtl/bcd_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the digit-serial BCD subtractor.
interface bcd_serial_subtractor_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   Diff;
  logic                  Bout;
  logic                  invalid;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout, invalid
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout, invalid
  );
endinterface : bcd_serial_subtractor_if

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtract with borrow: d = a - b - bin, wrapped by +10 on underflow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   bin,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   bout,
  output logic                   bad
);

  // Five bits hold the full range -16..15, so bit 4 is the sign.
  logic [BCD_DIGIT_W:0] t;

  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - (BCD_DIGIT_W+1)'(bin);
    bout = t[BCD_DIGIT_W];
    d    = bout ? BCD_DIGIT_W'(t + (BCD_DIGIT_W+1)'(BCD_RADIX)) : t[BCD_DIGIT_W-1:0];
    bad  = (a > BCD_DIGIT_W'(BCD_RADIX - 1)) || (b > BCD_DIGIT_W'(BCD_RADIX - 1));
  end

endmodule : bcd_digit_sub

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor, LSD first: Diff = A - B - Bin, one digit per clock.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_serial_subtractor_if.slave   bus
);

  localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]       state_q,  state_n;
  logic [W-1:0]     a_q,      a_n;
  logic [W-1:0]     b_q,      b_n;
  logic [IDX_W-1:0] idx_q,    idx_n;
  logic             borrow_q, borrow_n;
  logic             busy_q,   busy_n;
  logic             done_q,   done_n;
  logic [W-1:0]     diff_q,   diff_n;
  logic             bout_q,   bout_n;
  logic             inv_q,    inv_n;

  logic [BCD_DIGIT_W-1:0] dig_a, dig_b, dig_d;
  logic                   dig_bout, dig_bad;

  // One digit slice shared across all positions, selected by idx.
  assign dig_a = a_q[BCD_DIGIT_W*int'(idx_q) +: BCD_DIGIT_W];
  assign dig_b = b_q[BCD_DIGIT_W*int'(idx_q) +: BCD_DIGIT_W];

  bcd_digit_sub u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout),
    .bad  (dig_bad)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      a_q      <= a_n;
      b_q      <= b_n;
      idx_q    <= idx_n;
      borrow_q <= borrow_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      diff_q   <= diff_n;
      bout_q   <= bout_n;
      inv_q    <= inv_n;
    end
  end

  // Next state and next register values.
  always_comb begin
    state_n  = state_q;
    a_n      = a_q;
    b_n      = b_q;
    idx_n    = idx_q;
    borrow_n = borrow_q;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    diff_n   = diff_q;
    bout_n   = bout_q;
    inv_n    = inv_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_n      = bus.A;
          b_n      = bus.B;
          borrow_n = bus.Bin;
          idx_n    = '0;
          diff_n   = '0;
          bout_n   = 1'b0;
          inv_n    = 1'b0;
          busy_n   = 1'b1;
          state_n  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_n[BCD_DIGIT_W*int'(idx_q) +: BCD_DIGIT_W] = dig_d;
        borrow_n = dig_bout;
        inv_n    = inv_q | dig_bad;
        if (idx_q == IDX_LAST) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          // A malformed operand yields a defined all-zero result.
          if (inv_n) begin
            diff_n = '0;
            bout_n = 1'b0;
          end else begin
            bout_n = dig_bout;
          end
        end else begin
          idx_n  = idx_q + IDX_W'(1);
          busy_n = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Diff    = diff_q;
  assign bus.Bout    = bout_q;
  assign bus.invalid = inv_q;

endmodule : bcd_serial_subtractor

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor: integer-arithmetic reference model plus literal checks.
module tb_bcd_serial_subtractor;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: decode to integers, subtract, fold negatives into the tens-complement.
  function automatic void model_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                    output logic [W-1:0] d, output logic bo, output logic inv);
    int av = 0;
    int bv = 0;
    int pw = 1;
    int r;
    logic [3:0] da, db;
    inv = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da > 4'd9 || db > 4'd9) inv = 1'b1;
      av += int'(da) * pw;
      bv += int'(db) * pw;
      pw *= 10;
    end
    r  = av - bv - int'(bin);
    bo = (r < 0);
    if (bo) r += pw;
    d = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (inv) begin
      d  = '0;
      bo = 1'b0;
    end
  endfunction

  // Model timeline: ph = -1 idle, 0..DIGITS-1 busy cycles, DIGITS = done cycle.
  int         ph = -1;
  logic [W-1:0] p_diff = '0, h_diff = '0;
  logic       p_bout = 1'b0, h_bout = 1'b0;
  logic       p_inv = 1'b0,  h_inv = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = -1; h_diff = '0; h_bout = 1'b0; h_inv = 1'b0;
    end else if (ph < 0) begin
      if (bus.start) begin
        model_sub(bus.A, bus.B, bus.Bin, p_diff, p_bout, p_inv);
        h_diff = '0; h_bout = 1'b0; h_inv = 1'b0;
        ph = 0;
      end
    end else if (ph == int'(DIGITS)) begin
      ph = -1;
    end else begin
      ph++;
      if (ph == int'(DIGITS)) begin
        h_diff = p_diff; h_bout = p_bout; h_inv = p_inv;
      end
    end
  end

  // Per-cycle compare against the model; result fields are only meaningful outside RUN.
  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(ph >= 0 && ph < int'(DIGITS)));
    chk("done", 32'(bus.done), 32'(ph == int'(DIGITS)));
    if (ph < 0 || ph == int'(DIGITS)) begin
      chk("Diff",    32'(bus.Diff),    32'(h_diff));
      chk("Bout",    32'(bus.Bout),    32'(h_bout));
      chk("invalid", 32'(bus.invalid), 32'(h_inv));
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input logic ei);
    int n;
    int busy_cnt;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = ~a; bus.B = ~b; bus.Bin = ~bin;
    n = 1;
    busy_cnt = int'(bus.busy);
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
      busy_cnt += int'(bus.busy);
    end
    chk({nm, " latency"}, 32'(n), 32'(DIGITS + 1));
    chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(DIGITS));
    chk({nm, " Diff"}, 32'(bus.Diff), 32'(ed));
    chk({nm, " Bout"}, 32'(bus.Bout), 32'(eb));
    chk({nm, " invalid"}, 32'(bus.invalid), 32'(ei));
  endtask

  initial begin
    int dcount;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset Diff", 32'(bus.Diff), 32'd0);
    rst = 1'b0;

    run_op("17-05-0", 8'h17, 8'h05, 1'b0, 8'h12, 1'b0, 1'b0);
    run_op("05-17-0", 8'h05, 8'h17, 1'b0, 8'h88, 1'b1, 1'b0);
    run_op("00-00-1", 8'h00, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0);
    run_op("99-99-0", 8'h99, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("50-01-1", 8'h50, 8'h01, 1'b1, 8'h48, 1'b0, 1'b0);
    run_op("1A-01-0", 8'h1A, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1);
    run_op("00-F0-0", 8'h00, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1);

    // start held high: exactly one acceptance per DIGITS+2 cycles.
    @(negedge clk);
    bus.A = 8'h42; bus.B = 8'h13; bus.Bin = 1'b0; bus.start = 1'b1;
    dcount = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      dcount += int'(bus.done);
      if (i == 12) bus.start = 1'b0;
    end
    chk("held start done count", 32'(dcount), 32'd3);
    chk("held start Diff", 32'(bus.Diff), 32'h29);
    repeat (2) @(negedge clk);

    // Asynchronous reset one cycle into RUN discards the operation.
    @(negedge clk);
    bus.A = 8'h31; bus.B = 8'h12; bus.Bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async rst busy", 32'(bus.busy), 32'd0);
    chk("async rst done", 32'(bus.done), 32'd0);
    chk("async rst Diff", 32'(bus.Diff), 32'd0);
    chk("async rst Bout", 32'(bus.Bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_op("31-12-0", 8'h31, 8'h12, 1'b0, 8'h19, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bcd_serial_subtractor
